// File: rtl/axi_mem_arbiter_pkg.sv
// axi_mem_arbiter_pkg
//   Shared definitions for the AXI memory arbiter slice.
//   Holds:
//     - the AXI channel field widths;
//     - the constant single-beat transaction attributes;
//     - the per-requester AXI IDs;
//     - the FSM state encoding and the requester/owner encoding.
package axi_mem_arbiter_pkg;

  localparam int AXI_ID_W    = 4;
  localparam int AXI_ADDR_W  = 64;
  localparam int AXI_LEN_W   = 8;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_CACHE_W = 4;
  localparam int AXI_PROT_W  = 3;
  localparam int AXI_QOS_W   = 4;
  localparam int AXI_DATA_W  = 64;
  localparam int AXI_STRB_W  = 8;
  localparam int AXI_RESP_W  = 2;

  // Single beat, 8 bytes, INCR, modifiable/non-bufferable, unprivileged.
  localparam logic [AXI_LEN_W-1:0]   AXI_LEN   = 8'd0;
  localparam logic [AXI_SIZE_W-1:0]  AXI_SIZE  = 3'b011;
  localparam logic [AXI_BURST_W-1:0] AXI_BURST = 2'b01;
  localparam logic [AXI_CACHE_W-1:0] AXI_CACHE = 4'b0010;
  localparam logic [AXI_PROT_W-1:0]  AXI_PROT  = 3'b000;
  localparam logic [AXI_QOS_W-1:0]   AXI_QOS   = 4'b0000;

  // The memory model picks the instruction or data array from the ID.
  localparam logic [AXI_ID_W-1:0] IF_ID = 4'b0001;
  localparam logic [AXI_ID_W-1:0] LS_ID = 4'b0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WADDR = 3'd3,
    ST_WRESP = 3'd4
  } state_e;

  typedef enum logic {
    OWNER_LS = 1'b0,
    OWNER_IF = 1'b1
  } owner_e;

endpackage

// File: rtl/axi_arb_grant.sv
// axi_arb_grant
//   Two-way grant generator for the IF and LS requesters.
//   Configuration macro AXI_ARB_RR_EN:
//     defined   - round robin on a tie; the loser of the last grant wins.
//                 last_grant_q updates on every grant and resets to LS.
//     undefined - fixed priority, LS always wins; purely combinational,
//                 so no clock or reset ports exist in this build.
//   Ports:
//     clk, rst    clock / synchronous active-high reset (round robin only)
//     en_i        grant allowed this cycle (arbiter idle)
//     if_valid_i  IF request pending
//     ls_valid_i  LS request pending
//     grant_if_o  IF granted this cycle
//     grant_ls_o  LS granted this cycle
module axi_arb_grant
  import axi_mem_arbiter_pkg::*;
(
`ifdef AXI_ARB_RR_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic en_i,
  input  logic if_valid_i,
  input  logic ls_valid_i,
  output logic grant_if_o,
  output logic grant_ls_o
);

`ifdef AXI_ARB_RR_EN
  owner_e last_grant_q;
  owner_e last_grant_d;

  always_comb begin
    grant_if_o   = en_i && if_valid_i && (!ls_valid_i || last_grant_q == OWNER_LS);
    grant_ls_o   = en_i && ls_valid_i && (!if_valid_i || last_grant_q == OWNER_IF);
    last_grant_d = last_grant_q;
    if (grant_if_o)      last_grant_d = OWNER_IF;
    else if (grant_ls_o) last_grant_d = OWNER_LS;
  end

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= OWNER_LS;
    else     last_grant_q <= last_grant_d;
  end
`else
  always_comb begin
    grant_ls_o = en_i && ls_valid_i;
    grant_if_o = en_i && if_valid_i && !ls_valid_i;
  end
`endif

endmodule

// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter
//   Shares one AXI4 master port between the instruction-fetch (IF, read
//   only) and load/store (LS, read/write) requesters. One single-beat
//   64-bit transaction is outstanding at a time; the response is returned
//   to its owner as a one-cycle pulse with no backpressure.
//   Configuration macro AXI_ARB_RR_EN selects round-robin tie breaking
//   (see axi_arb_grant); undefined gives fixed LS priority.
//   Ports:
//     clk, rst                  clock / synchronous active-high reset
//     if_req_*_i/o, if_rsp_*_o  IF request handshake + address, response
//     ls_req_*_i/o, ls_rsp_*_o  LS request handshake + fields, response
//     m_axi_aw/w/b/ar/r_*       AXI4 master port to the memory model
module axi_mem_arbiter
  import axi_mem_arbiter_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req_valid_i,
  output logic                   if_req_ready_o,
  input  logic [AXI_ADDR_W-1:0]  if_req_addr_i,
  output logic                   if_rsp_valid_o,
  output logic [31:0]            if_rsp_data_o,
  input  logic                   ls_req_valid_i,
  output logic                   ls_req_ready_o,
  input  logic                   ls_req_we_i,
  input  logic [AXI_ADDR_W-1:0]  ls_req_addr_i,
  input  logic [AXI_DATA_W-1:0]  ls_req_wdata_i,
  input  logic [AXI_STRB_W-1:0]  ls_req_wstrb_i,
  output logic                   ls_rsp_valid_o,
  output logic [AXI_DATA_W-1:0]  ls_rsp_data_o,
  output logic [AXI_ID_W-1:0]    m_axi_aw_id_o,
  output logic [AXI_ADDR_W-1:0]  m_axi_aw_addr_o,
  output logic [AXI_LEN_W-1:0]   m_axi_aw_len_o,
  output logic [AXI_SIZE_W-1:0]  m_axi_aw_size_o,
  output logic [AXI_BURST_W-1:0] m_axi_aw_burst_o,
  output logic [AXI_CACHE_W-1:0] m_axi_aw_cache_o,
  output logic [AXI_PROT_W-1:0]  m_axi_aw_prot_o,
  output logic [AXI_QOS_W-1:0]   m_axi_aw_qos_o,
  output logic                   m_axi_aw_valid_o,
  input  logic                   m_axi_aw_ready_i,
  output logic [AXI_DATA_W-1:0]  m_axi_w_data_o,
  output logic [AXI_STRB_W-1:0]  m_axi_w_strb_o,
  output logic                   m_axi_w_last_o,
  output logic                   m_axi_w_valid_o,
  input  logic                   m_axi_w_ready_i,
  input  logic [AXI_ID_W-1:0]    m_axi_b_id_i,
  input  logic [AXI_RESP_W-1:0]  m_axi_b_resp_i,
  input  logic                   m_axi_b_valid_i,
  output logic                   m_axi_b_ready_o,
  output logic [AXI_ID_W-1:0]    m_axi_ar_id_o,
  output logic [AXI_ADDR_W-1:0]  m_axi_ar_addr_o,
  output logic [AXI_LEN_W-1:0]   m_axi_ar_len_o,
  output logic [AXI_SIZE_W-1:0]  m_axi_ar_size_o,
  output logic [AXI_BURST_W-1:0] m_axi_ar_burst_o,
  output logic [AXI_CACHE_W-1:0] m_axi_ar_cache_o,
  output logic [AXI_PROT_W-1:0]  m_axi_ar_prot_o,
  output logic [AXI_QOS_W-1:0]   m_axi_ar_qos_o,
  output logic                   m_axi_ar_valid_o,
  input  logic                   m_axi_ar_ready_i,
  input  logic [AXI_ID_W-1:0]    m_axi_r_id_i,
  input  logic [AXI_DATA_W-1:0]  m_axi_r_data_i,
  input  logic [AXI_RESP_W-1:0]  m_axi_r_resp_i,
  input  logic                   m_axi_r_last_i,
  input  logic                   m_axi_r_valid_i,
  output logic                   m_axi_r_ready_o
);

  state_e                 state_q, state_d;
  owner_e                 owner_q;
  logic [AXI_ADDR_W-1:0]  addr_q;
  logic [AXI_DATA_W-1:0]  wdata_q;
  logic [AXI_STRB_W-1:0]  wstrb_q;
  logic                   aw_done_q, w_done_q;
  logic                   if_rsp_valid_q, ls_rsp_valid_q;
  logic [31:0]            if_rsp_data_q;
  logic [AXI_DATA_W-1:0]  ls_rsp_data_q;
  logic                   grant_if, grant_ls;
  logic                   r_fire, b_fire;

  // Response IDs/status are not used to route: only one transaction is in flight.
  logic unused_inputs;
  assign unused_inputs = ^{m_axi_b_id_i, m_axi_b_resp_i, m_axi_r_id_i,
                           m_axi_r_resp_i, m_axi_r_last_i};

  axi_arb_grant u_grant (
`ifdef AXI_ARB_RR_EN
    .clk        (clk),
    .rst        (rst),
`endif
    .en_i       (state_q == ST_IDLE),
    .if_valid_i (if_req_valid_i),
    .ls_valid_i (ls_req_valid_i),
    .grant_if_o (grant_if),
    .grant_ls_o (grant_ls)
  );

  assign r_fire = (state_q == ST_RDATA) && m_axi_r_valid_i;
  assign b_fire = (state_q == ST_WRESP) && m_axi_b_valid_i;

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the latched request/response registers are reset too; they
      // drive AXI and response outputs directly and must read 0 after reset.
      state_q        <= ST_IDLE;
      owner_q        <= OWNER_LS;
      addr_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      aw_done_q      <= 1'b0;
      w_done_q       <= 1'b0;
      if_rsp_valid_q <= 1'b0;
      ls_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= '0;
      ls_rsp_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (grant_if) begin
        owner_q <= OWNER_IF;
        addr_q  <= if_req_addr_i;
      end else if (grant_ls) begin
        owner_q <= OWNER_LS;
        addr_q  <= ls_req_addr_i;
        wdata_q <= ls_req_wdata_i;
        wstrb_q <= ls_req_wstrb_i;
      end
      // Per-channel handshake memory; cleared once WADDR is left.
      aw_done_q <= (state_d == ST_WADDR) && (aw_done_q || (m_axi_aw_valid_o && m_axi_aw_ready_i));
      w_done_q  <= (state_d == ST_WADDR) && (w_done_q  || (m_axi_w_valid_o  && m_axi_w_ready_i));
      if_rsp_valid_q <= r_fire && (owner_q == OWNER_IF);
      ls_rsp_valid_q <= (r_fire && (owner_q == OWNER_LS)) || b_fire;
      if (r_fire && owner_q == OWNER_IF) if_rsp_data_q <= m_axi_r_data_i[31:0];
      if (r_fire && owner_q == OWNER_LS) ls_rsp_data_q <= m_axi_r_data_i;
      else if (b_fire)                   ls_rsp_data_q <= '0;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned
    // (which would infer a latch).
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_if)      state_d = ST_RADDR;
        else if (grant_ls) state_d = ls_req_we_i ? ST_WADDR : ST_RADDR;
      end
      ST_RADDR: if (m_axi_ar_ready_i) state_d = ST_RDATA;
      ST_RDATA: if (m_axi_r_valid_i)  state_d = ST_IDLE;
      ST_WADDR: if ((aw_done_q || m_axi_aw_ready_i) && (w_done_q || m_axi_w_ready_i))
                  state_d = ST_WRESP;
      ST_WRESP: if (m_axi_b_valid_i)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    if_req_ready_o   = 1'b0;
    ls_req_ready_o   = 1'b0;
    m_axi_ar_valid_o = 1'b0;
    m_axi_aw_valid_o = 1'b0;
    m_axi_w_valid_o  = 1'b0;
    m_axi_r_ready_o  = 1'b0;
    m_axi_b_ready_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if_req_ready_o = grant_if;
        ls_req_ready_o = grant_ls;
      end
      ST_RADDR: m_axi_ar_valid_o = 1'b1;
      ST_RDATA: m_axi_r_ready_o  = 1'b1;
      ST_WADDR: begin
        m_axi_aw_valid_o = !aw_done_q;
        m_axi_w_valid_o  = !w_done_q;
      end
      ST_WRESP: m_axi_b_ready_o  = 1'b1;
      default: ;
    endcase
  end

  assign if_rsp_valid_o   = if_rsp_valid_q;
  assign if_rsp_data_o    = if_rsp_data_q;
  assign ls_rsp_valid_o   = ls_rsp_valid_q;
  assign ls_rsp_data_o    = ls_rsp_data_q;

  assign m_axi_aw_id_o    = LS_ID;
  assign m_axi_aw_addr_o  = addr_q;
  assign m_axi_aw_len_o   = AXI_LEN;
  assign m_axi_aw_size_o  = AXI_SIZE;
  assign m_axi_aw_burst_o = AXI_BURST;
  assign m_axi_aw_cache_o = AXI_CACHE;
  assign m_axi_aw_prot_o  = AXI_PROT;
  assign m_axi_aw_qos_o   = AXI_QOS;
  assign m_axi_w_data_o   = wdata_q;
  assign m_axi_w_strb_o   = wstrb_q;
  assign m_axi_w_last_o   = m_axi_w_valid_o;

  assign m_axi_ar_id_o    = (owner_q == OWNER_IF) ? IF_ID : LS_ID;
  assign m_axi_ar_addr_o  = addr_q;
  assign m_axi_ar_len_o   = AXI_LEN;
  assign m_axi_ar_size_o  = AXI_SIZE;
  assign m_axi_ar_burst_o = AXI_BURST;
  assign m_axi_ar_cache_o = AXI_CACHE;
  assign m_axi_ar_prot_o  = AXI_PROT;
  assign m_axi_ar_qos_o   = AXI_QOS;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb_axi_mem_arbiter
//   Directed bench for axi_mem_arbiter. Inputs are driven and outputs are
//   sampled on the falling clock edge; the DUT acts on the rising edge.
//   The arbitration expectations follow AXI_ARB_RR_EN when it is defined.
module tb_axi_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [63:0] if_req_addr;
  logic [31:0] if_rsp_data;
  logic        ls_req_valid, ls_req_ready, ls_req_we, ls_rsp_valid;
  logic [63:0] ls_req_addr, ls_req_wdata, ls_rsp_data;
  logic [7:0]  ls_req_wstrb;
  logic [3:0]  aw_id, ar_id, b_id, r_id;
  logic [63:0] aw_addr, ar_addr, w_data, r_data;
  logic [7:0]  aw_len, ar_len, w_strb;
  logic [2:0]  aw_size, ar_size, aw_prot, ar_prot;
  logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
  logic [3:0]  aw_cache, ar_cache, aw_qos, ar_qos;
  logic        aw_valid, aw_ready, w_valid, w_ready, w_last;
  logic        b_valid, b_ready, ar_valid, ar_ready, r_valid, r_ready, r_last;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req_valid_i(if_req_valid), .if_req_ready_o(if_req_ready), .if_req_addr_i(if_req_addr),
    .if_rsp_valid_o(if_rsp_valid), .if_rsp_data_o(if_rsp_data),
    .ls_req_valid_i(ls_req_valid), .ls_req_ready_o(ls_req_ready), .ls_req_we_i(ls_req_we),
    .ls_req_addr_i(ls_req_addr), .ls_req_wdata_i(ls_req_wdata), .ls_req_wstrb_i(ls_req_wstrb),
    .ls_rsp_valid_o(ls_rsp_valid), .ls_rsp_data_o(ls_rsp_data),
    .m_axi_aw_id_o(aw_id), .m_axi_aw_addr_o(aw_addr), .m_axi_aw_len_o(aw_len),
    .m_axi_aw_size_o(aw_size), .m_axi_aw_burst_o(aw_burst), .m_axi_aw_cache_o(aw_cache),
    .m_axi_aw_prot_o(aw_prot), .m_axi_aw_qos_o(aw_qos), .m_axi_aw_valid_o(aw_valid),
    .m_axi_aw_ready_i(aw_ready),
    .m_axi_w_data_o(w_data), .m_axi_w_strb_o(w_strb), .m_axi_w_last_o(w_last),
    .m_axi_w_valid_o(w_valid), .m_axi_w_ready_i(w_ready),
    .m_axi_b_id_i(b_id), .m_axi_b_resp_i(b_resp), .m_axi_b_valid_i(b_valid), .m_axi_b_ready_o(b_ready),
    .m_axi_ar_id_o(ar_id), .m_axi_ar_addr_o(ar_addr), .m_axi_ar_len_o(ar_len),
    .m_axi_ar_size_o(ar_size), .m_axi_ar_burst_o(ar_burst), .m_axi_ar_cache_o(ar_cache),
    .m_axi_ar_prot_o(ar_prot), .m_axi_ar_qos_o(ar_qos), .m_axi_ar_valid_o(ar_valid),
    .m_axi_ar_ready_i(ar_ready),
    .m_axi_r_id_i(r_id), .m_axi_r_data_i(r_data), .m_axi_r_resp_i(r_resp), .m_axi_r_last_i(r_last),
    .m_axi_r_valid_i(r_valid), .m_axi_r_ready_o(r_ready)
  );

  task automatic idle_inputs();
    if_req_valid = 0; if_req_addr = '0;
    ls_req_valid = 0; ls_req_we = 0; ls_req_addr = '0; ls_req_wdata = '0; ls_req_wstrb = '0;
    aw_ready = 0; w_ready = 0; b_valid = 0; b_id = 4'hF; b_resp = 2'b10;
    ar_ready = 0; r_valid = 0; r_data = '0; r_id = 4'hF; r_resp = 2'b10; r_last = 1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    checks++; if ({if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid} !== 4'b0)
      begin errors++; $display("FAIL reset_rdy_rsp: got %b want 0000", {if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid}); end
    checks++; if ({ar_valid, aw_valid, w_valid, w_last, r_ready, b_ready} !== 6'b0)
      begin errors++; $display("FAIL reset_axi_ctl: got %b want 000000", {ar_valid, aw_valid, w_valid, w_last, r_ready, b_ready}); end
    checks++; if ({ar_addr, aw_addr, w_data, w_strb, if_rsp_data, ls_rsp_data} !== '0)
      begin errors++; $display("FAIL reset_data: ar_addr=%h w_data=%h w_strb=%h if_rsp=%h ls_rsp=%h want 0", ar_addr, w_data, w_strb, if_rsp_data, ls_rsp_data); end
    checks++; if ({ar_id, aw_id} !== 8'h00)
      begin errors++; $display("FAIL reset_ids: ar_id=%h aw_id=%h want 0 0", ar_id, aw_id); end
    checks++; if ({aw_len, aw_size, aw_burst, aw_cache, aw_prot, aw_qos} !== {8'd0, 3'b011, 2'b01, 4'b0010, 3'b000, 4'b0000})
      begin errors++; $display("FAIL aw_attrs: len=%h size=%b burst=%b cache=%b prot=%b qos=%b", aw_len, aw_size, aw_burst, aw_cache, aw_prot, aw_qos); end
    checks++; if ({ar_len, ar_size, ar_burst, ar_cache, ar_prot, ar_qos} !== {8'd0, 3'b011, 2'b01, 4'b0010, 3'b000, 4'b0000})
      begin errors++; $display("FAIL ar_attrs: len=%h size=%b burst=%b cache=%b prot=%b qos=%b", ar_len, ar_size, ar_burst, ar_cache, ar_prot, ar_qos); end
    rst = 0;
    @(negedge clk);
  endtask

  // Always-ready slave; grant at cycle 0, AR at 1, R at 2, response at 3.
  task automatic test_if_fetch();
    ar_ready = 1; r_valid = 1; r_data = 64'hDEAD_BEEF_1234_5678;
    if_req_valid = 1; if_req_addr = 64'h8000_0000;
    #1;
    checks++; if ({if_req_ready, ls_req_ready} !== 2'b10)
      begin errors++; $display("FAIL if_grant: if/ls ready=%b want 10", {if_req_ready, ls_req_ready}); end
    @(negedge clk); if_req_valid = 0;
    checks++; if ({ar_valid, ar_id, ar_addr} !== {1'b1, 4'b0001, 64'h8000_0000})
      begin errors++; $display("FAIL if_ar: valid=%b id=%h addr=%h want 1 1 80000000", ar_valid, ar_id, ar_addr); end
    @(negedge clk);
    checks++; if ({r_ready, if_rsp_valid} !== 2'b10)
      begin errors++; $display("FAIL if_rdata: r_ready=%b if_rsp_valid=%b want 1 0", r_ready, if_rsp_valid); end
    @(negedge clk); r_valid = 0;
    checks++; if ({if_rsp_valid, if_rsp_data, ls_rsp_valid} !== {1'b1, 32'h1234_5678, 1'b0})
      begin errors++; $display("FAIL if_rsp: valid=%b data=%h ls_valid=%b want 1 12345678 0", if_rsp_valid, if_rsp_data, ls_rsp_valid); end
    @(negedge clk);
    checks++; if (if_rsp_valid !== 1'b0)
      begin errors++; $display("FAIL if_rsp_pulse: valid=%b want 0", if_rsp_valid); end
  endtask

  task automatic test_ls_read();
    ar_ready = 1; r_valid = 1; r_data = 64'h0123_4567_89AB_CDEF;
    ls_req_valid = 1; ls_req_we = 0; ls_req_addr = 64'h8000_1000;
    #1;
    checks++; if ({if_req_ready, ls_req_ready} !== 2'b01)
      begin errors++; $display("FAIL ls_rd_grant: if/ls ready=%b want 01", {if_req_ready, ls_req_ready}); end
    @(negedge clk); ls_req_valid = 0;
    checks++; if ({ar_valid, ar_id, ar_addr} !== {1'b1, 4'b0000, 64'h8000_1000})
      begin errors++; $display("FAIL ls_ar: valid=%b id=%h addr=%h want 1 0 80001000", ar_valid, ar_id, ar_addr); end
    repeat (2) @(negedge clk); r_valid = 0;
    checks++; if ({ls_rsp_valid, ls_rsp_data, if_rsp_valid} !== {1'b1, 64'h0123_4567_89AB_CDEF, 1'b0})
      begin errors++; $display("FAIL ls_rd_rsp: valid=%b data=%h if_valid=%b want 1 0123456789abcdef 0", ls_rsp_valid, ls_rsp_data, if_rsp_valid); end
    @(negedge clk);
  endtask

  task automatic test_ls_write();
    aw_ready = 1; w_ready = 1; b_valid = 0;
    ls_req_valid = 1; ls_req_we = 1; ls_req_addr = 64'h8000_2000;
    ls_req_wdata = 64'hAA55; ls_req_wstrb = 8'hFF;
    #1;
    checks++; if (ls_req_ready !== 1'b1)
      begin errors++; $display("FAIL ls_wr_grant: ls_ready=%b want 1", ls_req_ready); end
    @(negedge clk); ls_req_valid = 0;
    checks++; if ({aw_valid, w_valid, w_last, ar_valid} !== 4'b1110)
      begin errors++; $display("FAIL ls_wr_valids: aw/w/last/ar=%b want 1110", {aw_valid, w_valid, w_last, ar_valid}); end
    checks++; if ({aw_id, aw_addr, w_data, w_strb} !== {4'h0, 64'h8000_2000, 64'hAA55, 8'hFF})
      begin errors++; $display("FAIL ls_wr_fields: id=%h addr=%h data=%h strb=%h", aw_id, aw_addr, w_data, w_strb); end
    // Three WRESP cycles without b_valid; an IF request must not be granted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if_req_valid = 1; if_req_addr = 64'h8000_0040;
      #1;
      checks++; if ({aw_valid, w_valid, b_ready, if_req_ready, ls_rsp_valid} !== 5'b00100)
        begin errors++; $display("FAIL ls_wresp_wait%0d: aw/w/b_rdy/if_rdy/rsp=%b want 00100", i, {aw_valid, w_valid, b_ready, if_req_ready, ls_rsp_valid}); end
    end
    if_req_valid = 0;
    @(negedge clk); b_valid = 1;
    @(negedge clk); b_valid = 0;
    checks++; if ({ls_rsp_valid, ls_rsp_data, b_ready} !== {1'b1, 64'h0, 1'b0})
      begin errors++; $display("FAIL ls_wr_ack: valid=%b data=%h b_ready=%b want 1 0 0", ls_rsp_valid, ls_rsp_data, b_ready); end
    @(negedge clk);
    checks++; if (ls_rsp_valid !== 1'b0)
      begin errors++; $display("FAIL ls_wr_pulse: valid=%b want 0", ls_rsp_valid); end
  endtask

  // AW accepted first; W must stay valid alone until its own handshake.
  task automatic test_w_split();
    aw_ready = 1; w_ready = 0; b_valid = 0;
    ls_req_valid = 1; ls_req_we = 1; ls_req_addr = 64'h8000_2008;
    ls_req_wdata = 64'h1122_3344_5566_7788; ls_req_wstrb = 8'h0F;
    @(negedge clk); ls_req_valid = 0;
    checks++; if ({aw_valid, w_valid} !== 2'b11)
      begin errors++; $display("FAIL split_both: aw/w=%b want 11", {aw_valid, w_valid}); end
    @(negedge clk); aw_ready = 0;
    checks++; if ({aw_valid, w_valid, w_data, w_strb} !== {2'b01, 64'h1122_3344_5566_7788, 8'h0F})
      begin errors++; $display("FAIL split_w_only: aw/w=%b data=%h strb=%h want 01", {aw_valid, w_valid}, w_data, w_strb); end
    w_ready = 1;
    @(negedge clk); w_ready = 0;
    checks++; if ({aw_valid, w_valid, b_ready} !== 3'b001)
      begin errors++; $display("FAIL split_wresp: aw/w/b_rdy=%b want 001", {aw_valid, w_valid, b_ready}); end
    b_valid = 1;
    @(negedge clk); b_valid = 0;
    checks++; if (ls_rsp_valid !== 1'b1)
      begin errors++; $display("FAIL split_ack: valid=%b want 1", ls_rsp_valid); end
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    logic [1:0] want [4];
`ifdef AXI_ARB_RR_EN
    want = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
    want = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    apply_reset();
    ar_ready = 1; r_valid = 1; r_data = 64'hCAFE_F00D_0BAD_BEEF;
    if_req_valid = 1; if_req_addr = 64'h8000_0100;
    ls_req_valid = 1; ls_req_we = 0; ls_req_addr = 64'h8000_1100;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if ({if_req_ready, ls_req_ready} !== want[k])
        begin errors++; $display("FAIL arb_grant%0d: if/ls ready=%b want %b", k, {if_req_ready, ls_req_ready}, want[k]); end
      @(negedge clk);
      if (k == 3) begin if_req_valid = 0; ls_req_valid = 0; end
      checks++; if (ar_id !== (want[k][1] ? 4'b0001 : 4'b0000))
        begin errors++; $display("FAIL arb_id%0d: ar_id=%h want %h", k, ar_id, (want[k][1] ? 4'b0001 : 4'b0000)); end
      repeat (2) @(negedge clk);
    end
    r_valid = 0; ar_ready = 0;
  endtask

  task automatic test_ar_stall();
    ar_ready = 0; r_valid = 0;
    if_req_valid = 1; if_req_addr = 64'h8000_3000;
    @(negedge clk);
    ls_req_valid = 1; ls_req_we = 0; ls_req_addr = 64'h8000_4000;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if ({ar_valid, ar_id, ar_addr, if_req_ready, ls_req_ready} !== {1'b1, 4'b0001, 64'h8000_3000, 2'b00})
        begin errors++; $display("FAIL ar_stall%0d: valid=%b id=%h addr=%h if/ls ready=%b", i, ar_valid, ar_id, ar_addr, {if_req_ready, ls_req_ready}); end
      if (i == 4) ar_ready = 1;
      @(negedge clk);
    end
    ar_ready = 0; if_req_valid = 0; ls_req_valid = 0;
    r_valid = 1; r_data = 64'h0000_0000_0000_0013;
    @(negedge clk); r_valid = 0;
    checks++; if ({if_rsp_valid, if_rsp_data} !== {1'b1, 32'h13})
      begin errors++; $display("FAIL ar_stall_rsp: valid=%b data=%h want 1 13", if_rsp_valid, if_rsp_data); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    ar_ready = 1; r_valid = 0;
    ls_req_valid = 1; ls_req_we = 0; ls_req_addr = 64'h8000_5000;
    @(negedge clk); ls_req_valid = 0;
    @(negedge clk);
    checks++; if (r_ready !== 1'b1)
      begin errors++; $display("FAIL mid_rdata: r_ready=%b want 1", r_ready); end
    rst = 1;
    @(negedge clk); rst = 0;
    checks++; if ({ar_valid, aw_valid, w_valid, r_ready, b_ready, if_rsp_valid, ls_rsp_valid} !== 7'b0)
      begin errors++; $display("FAIL mid_reset: ar/aw/w/r_rdy/b_rdy/rsp=%b want 0", {ar_valid, aw_valid, w_valid, r_ready, b_ready, if_rsp_valid, ls_rsp_valid}); end
    r_valid = 1; r_data = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk); r_valid = 0;
    @(negedge clk);
    checks++; if ({if_rsp_valid, ls_rsp_valid, ls_rsp_data} !== {2'b00, 64'h0})
      begin errors++; $display("FAIL mid_late_r: if/ls rsp=%b data=%h want 00 0", {if_rsp_valid, ls_rsp_valid}, ls_rsp_data); end
    ls_req_valid = 1;
    #1;
    checks++; if (ls_req_ready !== 1'b1)
      begin errors++; $display("FAIL mid_idle: ls_ready=%b want 1", ls_req_ready); end
    @(negedge clk); ls_req_valid = 0;
  endtask

  initial begin
    test_reset();
    test_if_fetch();
    test_ls_read();
    test_ls_write();
    test_w_split();
    test_arbitration();
    test_ar_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
